// File: rtl/process_compare_engine.sv
// One process slot: executes a loadable compare/add/jump program over a register file, one instruction per cycle.
// A run stops on HALT, an illegal opcode, falling off the end of the program, or an exhausted step budget.
module process_compare_engine #(
  parameter  int WIDTH      = 8,
  parameter  int NREGS      = 16,
  parameter  int PROG_DEPTH = 32,
  parameter  int MAX_STEPS  = 100,
  localparam int RW         = $clog2(NREGS),
  localparam int PW         = $clog2(PROG_DEPTH),
  localparam int IW         = 4 + 3 * RW + WIDTH,
  localparam int SWN        = $clog2(MAX_STEPS + 1),
  localparam int SW         = (SWN > 8) ? SWN : 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             prog_we,
  input  logic [PW-1:0]    prog_addr,
  input  logic [IW-1:0]    prog_data,
  input  logic             start,
  output logic             busy,
  output logic             stop,
  output logic [WIDTH-1:0] return_code,
  output logic             timeout,
  output logic [PW:0]      pc,
  output logic [SW-1:0]    steps,
  input  logic [RW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [RW-1:0]    d;
    logic [RW-1:0]    a;
    logic [RW-1:0]    b;
    logic [WIDTH-1:0] imm;
  } instr_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_SETI = 4'd1;
  localparam logic [3:0] OP_GE   = 4'd2;
  localparam logic [3:0] OP_GT   = 4'd3;
  localparam logic [3:0] OP_LE   = 4'd4;
  localparam logic [3:0] OP_LT   = 4'd5;
  localparam logic [3:0] OP_NE   = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_JT   = 4'd8;
  localparam logic [3:0] OP_JF   = 4'd9;
  localparam logic [3:0] OP_ADD  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  localparam logic [PW:0]      PC_END  = (PW + 1)'(PROG_DEPTH);
  localparam logic [SW-1:0]    LAST_ST = SW'(MAX_STEPS - 1);
  localparam logic [WIDTH-1:0] RC_ILL  = '1;
  localparam logic [WIDTH-1:0] RC_TMO  = RC_ILL - WIDTH'(1);

  state_t           state;
  logic [IW-1:0]    mem  [PROG_DEPTH];
  logic [WIDTH-1:0] regs [NREGS];
  instr_t           ins;
  logic [WIDTH-1:0] ra, rb;
  logic             cmp;
  logic [PW:0]      pc_inc, pc_tgt;

  assign rd_data = regs[rd_addr];
  assign ins     = instr_t'(mem[pc[PW-1:0]]);
  assign ra      = regs[ins.a];
  assign rb      = regs[ins.b];
  assign pc_inc  = pc + (PW + 1)'(1);
  assign pc_tgt  = {1'b0, ins.imm[PW-1:0]};

  always_comb begin
    cmp = 1'b0;
    case (ins.op)
      OP_GE:   cmp = (ra >= rb);
      OP_GT:   cmp = (ra >  rb);
      OP_LE:   cmp = (ra <= rb);
      OP_LT:   cmp = (ra <  rb);
      OP_NE:   cmp = (ra != rb);
      OP_EQ:   cmp = (ra == rb);
      default: cmp = 1'b0;
    endcase
  end

  // Program memory is deliberately outside reset so a reset mid-run keeps the loaded program.
  always_ff @(posedge clock) begin
    if (prog_we && state != RUN) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      steps       <= '0;
      return_code <= '0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      stop        <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            stop        <= 1'b0;
            pc          <= '0;
            steps       <= '0;
            return_code <= '0;
            timeout     <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
          end
        end
        RUN: begin
          if (pc == PC_END) begin
            state       <= DONE;
            busy        <= 1'b0;
            stop        <= 1'b1;
            return_code <= '0;
          end else if (ins.op == OP_HALT) begin
            state       <= DONE;
            busy        <= 1'b0;
            stop        <= 1'b1;
            return_code <= ins.imm;
          end else if (ins.op > OP_HALT) begin
            state       <= DONE;
            busy        <= 1'b0;
            stop        <= 1'b1;
            return_code <= RC_ILL;
          end else begin
            steps <= steps + SW'(1);
            pc    <= pc_inc;
            case (ins.op)
              OP_SETI: regs[ins.d] <= ins.imm;
              OP_ADD:  regs[ins.d] <= ra + rb;
              OP_JT:   if (ra != '0) pc <= pc_tgt;
              OP_JF:   if (ra == '0) pc <= pc_tgt;
              OP_GE, OP_GT, OP_LE, OP_LT, OP_NE, OP_EQ:
                regs[ins.d] <= {{(WIDTH-1){1'b0}}, cmp};
              default: ;
            endcase
            // Budget exhaustion only applies to ordinary instructions; HALT and illegal exit above.
            if (steps == LAST_ST) begin
              state       <= DONE;
              busy        <= 1'b0;
              stop        <= 1'b1;
              timeout     <= 1'b1;
              return_code <= RC_TMO;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_process_compare_engine.sv
// Directed bench for process_compare_engine: loads small programs and checks registers and run status.
module tb_process_compare_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [23:0] prog_data = '0;
  logic        start = 1'b0;
  logic        busy, stop, timeout;
  logic [7:0]  return_code;
  logic [5:0]  pc;
  logic [7:0]  steps;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rd_data;

  int checks = 0;
  int errors = 0;
  logic [23:0] prog [$];

  process_compare_engine dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .busy(busy), .stop(stop),
    .return_code(return_code), .timeout(timeout), .pc(pc), .steps(steps),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] mk(input logic [3:0] op, input logic [3:0] d,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic [7:0] imm);
    return {op, d, a, b, imm};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) begin
      prog_we   = 1'b1;
      prog_addr = 5'(i);
      prog_data = (i < prog.size()) ? prog[i] : 24'h0;
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic wait_stop(input string name);
    int n;
    n = 0;
    while (!stop && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (!stop) begin
      errors++;
      $display("FAIL %s stop_wait: stop=%0b after %0d cycles, required 1", name, stop, n);
    end
  endtask

  task automatic run_prog(input string name);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_stop(name);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #20 reset = 1'b0;
    tick();
    checks++;
    if ({busy, stop, timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/stop/timeout=%b required 000", {busy, stop, timeout});
    end
    checks++;
    if (pc !== 6'd0 || steps !== 8'd0 || return_code !== 8'd0) begin
      errors++;
      $display("FAIL reset_counters: pc=%0d steps=%0d rc=%0d required 0 0 0", pc, steps, return_code);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 8'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %0d required 0", i, rd_data);
      end
    end
  endtask

  task automatic test_legacy();
    logic [7:0] exp_r [14];
    exp_r = '{8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
              8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    prog = '{mk(1, 0, 0, 0, 0),  mk(1, 1, 0, 0, 1),
             mk(2, 2, 0, 1, 0),  mk(3, 3, 0, 1, 0),  mk(4, 4, 1, 0, 0),
             mk(5, 5, 1, 0, 0),  mk(6, 6, 0, 0, 0),  mk(7, 7, 0, 1, 0),
             mk(2, 8, 1, 0, 0),  mk(3, 9, 1, 0, 0),  mk(4, 10, 0, 1, 0),
             mk(5, 11, 0, 1, 0), mk(6, 12, 0, 1, 0), mk(7, 13, 1, 1, 0),
             mk(11, 0, 0, 0, 0)};
    load_prog();
    run_prog("legacy");
    checks++;
    if (stop !== 1'b1 || return_code !== 8'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL legacy_status: stop=%b rc=%0d timeout=%b required 1 0 0", stop, return_code, timeout);
    end
    checks++;
    if (steps !== 8'd14) begin
      errors++;
      $display("FAIL legacy_steps: got %0d required 14", steps);
    end
    for (int i = 0; i < 14; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== exp_r[i]) begin
        errors++;
        $display("FAIL legacy_r%0d: got %0d required %0d", i, rd_data, exp_r[i]);
      end
    end
  endtask

  task automatic load_countdown();
    prog = '{mk(1, 0, 0, 0, 5), mk(1, 1, 0, 0, 1), mk(1, 2, 0, 0, 0),
             mk(5, 3, 2, 0, 0), mk(9, 0, 3, 0, 7), mk(10, 2, 2, 1, 0),
             mk(8, 0, 1, 0, 3), mk(11, 0, 0, 0, 7)};
    load_prog();
  endtask

  task automatic check_countdown(input string name);
    rd_addr = 4'd2;
    #1;
    checks++;
    if (rd_data !== 8'd5) begin
      errors++;
      $display("FAIL %s_r2: got %0d required 5", name, rd_data);
    end
    checks++;
    if (return_code !== 8'd7 || steps !== 8'd25 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: rc=%0d steps=%0d timeout=%b required 7 25 0", name, return_code, steps, timeout);
    end
  endtask

  task automatic test_countdown();
    load_countdown();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_addr = 4'd0;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_data !== 8'd0 || pc !== 6'd0) begin
      errors++;
      $display("FAIL latency_run_entry: busy=%b r0=%0d pc=%0d required 1 0 0", busy, rd_data, pc);
    end
    tick();
    checks++;
    if (rd_data !== 8'd5 || pc !== 6'd1 || steps !== 8'd1) begin
      errors++;
      $display("FAIL latency_first_retire: r0=%0d pc=%0d steps=%0d required 5 1 1", rd_data, pc, steps);
    end
    wait_stop("countdown");
    check_countdown("countdown");
    checks++;
    if (pc !== 6'd7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL countdown_pc: pc=%0d busy=%b required 7 0", pc, busy);
    end
  endtask

  task automatic test_timeout_protect();
    logic [7:0] s;
    prog = '{mk(1, 1, 0, 0, 1), mk(8, 0, 1, 0, 1)};
    load_prog();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    prog_we   = 1'b1;
    prog_addr = 5'd1;
    prog_data = mk(11, 0, 0, 0, 8'd5);
    tick();
    prog_we = 1'b0;
    s = steps;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (steps !== s + 8'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: steps=%0d busy=%b required %0d 1", steps, busy, s + 8'd1);
    end
    wait_stop("timeout");
    checks++;
    if (timeout !== 1'b1 || steps !== 8'd100 || return_code !== 8'd254 || stop !== 1'b1) begin
      errors++;
      $display("FAIL timeout_status: timeout=%b steps=%0d rc=%0d stop=%b required 1 100 254 1",
               timeout, steps, return_code, stop);
    end
    run_prog("timeout_rerun");
    checks++;
    if (timeout !== 1'b1 || steps !== 8'd100 || return_code !== 8'd254) begin
      errors++;
      $display("FAIL protect_rerun: timeout=%b steps=%0d rc=%0d required 1 100 254", timeout, steps, return_code);
    end
  endtask

  task automatic test_wrap();
    prog = '{mk(1, 0, 0, 0, 200), mk(1, 1, 0, 0, 100), mk(10, 2, 0, 1, 0)};
    load_prog();
    run_prog("wrap");
    rd_addr = 4'd2;
    #1;
    checks++;
    if (rd_data !== 8'd44) begin
      errors++;
      $display("FAIL wrap_r2: got %0d required 44", rd_data);
    end
    checks++;
    if (return_code !== 8'd0 || timeout !== 1'b0 || pc !== 6'd32 || steps !== 8'd32) begin
      errors++;
      $display("FAIL falloff_status: rc=%0d timeout=%b pc=%0d steps=%0d required 0 0 32 32",
               return_code, timeout, pc, steps);
    end
  endtask

  task automatic test_illegal();
    prog = '{mk(1, 0, 0, 0, 1), mk(1, 1, 0, 0, 2), mk(13, 0, 0, 0, 0), mk(11, 0, 0, 0, 3)};
    load_prog();
    run_prog("illegal");
    checks++;
    if (stop !== 1'b1 || return_code !== 8'd255 || pc !== 6'd2 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL illegal_status: stop=%b rc=%0d pc=%0d timeout=%b required 1 255 2 0",
               stop, return_code, pc, timeout);
    end
  endtask

  task automatic test_same_cycle();
    prog = {};
    load_prog();
    pulse_reset();
    prog_we   = 1'b1;
    prog_addr = 5'd0;
    prog_data = mk(11, 0, 0, 0, 8'h42);
    start     = 1'b1;
    tick();
    prog_we = 1'b0;
    start   = 1'b0;
    wait_stop("same_cycle");
    checks++;
    if (return_code !== 8'h42 || steps !== 8'd0 || pc !== 6'd0) begin
      errors++;
      $display("FAIL write_start_same_cycle: rc=%0h steps=%0d pc=%0d required 42 0 0", return_code, steps, pc);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    load_countdown();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (steps !== 8'd10 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (steps !== 8'd10) begin
      errors++;
      $display("FAIL midrun_reach_step10: steps=%0d required 10", steps);
    end
    pulse_reset();
    checks++;
    if ({busy, stop} !== 2'b00 || pc !== 6'd0 || steps !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset_state: busy/stop=%b pc=%0d steps=%0d required 00 0 0", {busy, stop}, pc, steps);
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 8'd0) begin
        errors++;
        $display("FAIL midrun_reset_r%0d: got %0d required 0", i, rd_data);
      end
    end
    tick();
    run_prog("restart");
    check_countdown("restart");
  endtask

  initial begin
    test_reset();
    test_legacy();
    test_countdown();
    test_timeout_protect();
    test_wrap();
    test_illegal();
    test_same_cycle();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
